// File: rtl/cpu_pkg.sv
// cpu_pkg: shared memory-controller opcode and loader state types
package cpu_pkg;
  localparam int LINE_W = 512;
  typedef enum logic [1:0] {OP_IDLE = 2'b00, OP_READ = 2'b01, OP_WRITE = 2'b11} mc_op_t;
  typedef enum logic [3:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_UNPACK, S_RUN, S_WB_READ, S_WB_REQ, S_WB_WAIT, S_DONE
  } state_t;
endpackage

// File: rtl/cpu_line_buf.sv
// cpu_line_buf: 512-bit line register with full-line capture, 32-bit word insert and word select
module cpu_line_buf
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic [LINE_W-1:0] ld_data,
  input  logic              ins,
  input  logic [3:0]        ins_idx,
  input  logic [31:0]       ins_data,
  input  logic [3:0]        sel_idx,
  output logic [LINE_W-1:0] line,
  output logic [31:0]       word
);
  always_ff @(posedge clk or posedge rst)
    if (rst) line <= '0;
    else if (ld) line <= ld_data;
    else if (ins) line[{ins_idx, 5'd0} +: 32] <= ins_data;
  assign word = line[{sel_idx, 5'd0} +: 32];
endmodule

// File: rtl/cpu_host_loader.sv
// cpu_host_loader: loads IM/DM from host lines, runs the CPU until halt, writes DM lines back (mc_* host side, ex_* CPU side)
module cpu_host_loader
  import cpu_pkg::*;
#(
  parameter int          IM_LINES   = 4,
  parameter int          DM_LINES   = 4,
  parameter int          WB_LINES   = 1,
  parameter logic [15:0] WB_DM_BASE = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       host_rd_base,
  input  logic [31:0]       host_wr_base,
  output logic [1:0]        mc_op,
  output logic [31:0]       mc_addr,
  input  logic              mc_ready,
  input  logic              mc_rd_valid,
  input  logic [LINE_W-1:0] mc_rd_data,
  output logic [LINE_W-1:0] mc_wrt_data,
  input  logic              mc_tx_done,
  output logic [15:0]       ex_addr,
  output logic [31:0]       ex_wrt_data,
  output logic              ex_im_wrt_en,
  output logic              ex_mem_wrt_en,
  output logic              ex_mem_rd_en,
  input  logic [31:0]       ex_rd_data,
  input  logic              cpu_halt,
  output logic              cpu_run,
  output logic              busy,
  output logic              done
);
  localparam logic [15:0] IM_LAST = 16'(IM_LINES - 1);
  localparam logic [15:0] DM_LAST = 16'(DM_LINES - 1);
  localparam logic [15:0] WB_LAST = 16'(WB_LINES - 1);
  state_t      state;
  logic        ph;
  logic [15:0] ln;
  logic [4:0]  wd;
  logic [31:0] wr_base;
  logic [31:0] word;
  logic        last_line;
  logic        more;
  assign last_line = ln == (ph ? DM_LAST : IM_LAST);
  assign more = !last_line || (!ph && DM_LINES != 0);
  assign ex_wrt_data = state == S_UNPACK ? word : '0;
  cpu_line_buf u_buf (
    .clk      (clk),
    .rst      (rst),
    .ld       (state == S_RD_WAIT && mc_rd_valid),
    .ld_data  (mc_rd_data),
    .ins      (state == S_WB_READ && wd != 5'd0),
    .ins_idx  (wd[3:0] - 4'd1),
    .ins_data (ex_rd_data),
    .sel_idx  (wd[3:0]),
    .line     (mc_wrt_data),
    .word     (word)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state         <= S_IDLE;
      ph            <= 1'b0;
      ln            <= '0;
      wd            <= '0;
      wr_base       <= '0;
      mc_op         <= OP_IDLE;
      mc_addr       <= '0;
      ex_addr       <= '0;
      ex_im_wrt_en  <= 1'b0;
      ex_mem_wrt_en <= 1'b0;
      ex_mem_rd_en  <= 1'b0;
      cpu_run       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else
      case (state)
        S_IDLE:
          if (start) begin
            wr_base <= host_wr_base;
            mc_addr <= host_rd_base;
            ln      <= '0;
            wd      <= '0;
            ph      <= IM_LINES == 0;
            busy    <= 1'b1;
            if (IM_LINES == 0 && DM_LINES == 0) begin
              state   <= S_RUN;
              cpu_run <= 1'b1;
            end else begin
              state <= S_RD_REQ;
              mc_op <= OP_READ;
            end
          end
        S_RD_REQ:
          if (mc_ready) begin
            state <= S_RD_WAIT;
            mc_op <= OP_IDLE;
          end
        S_RD_WAIT:
          if (mc_rd_valid) begin
            state         <= S_UNPACK;
            wd            <= '0;
            ex_addr       <= {ln[9:0], 6'd0};
            ex_im_wrt_en  <= !ph;
            ex_mem_wrt_en <= ph;
          end
        S_UNPACK:
          if (wd[3:0] != 4'd15) begin
            wd      <= wd + 5'd1;
            ex_addr <= ex_addr + 16'd4;
          end else begin
            ex_im_wrt_en  <= 1'b0;
            ex_mem_wrt_en <= 1'b0;
            wd            <= '0;
            if (more) begin
              state   <= S_RD_REQ;
              mc_op   <= OP_READ;
              mc_addr <= mc_addr + 32'd64;
              ln      <= last_line ? 16'd0 : ln + 16'd1;
              ph      <= ph | last_line;
            end else begin
              state   <= S_RUN;
              cpu_run <= 1'b1;
            end
          end
        S_RUN:
          if (cpu_halt) begin
            cpu_run <= 1'b0;
            if (WB_LINES == 0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state        <= S_WB_READ;
              ln           <= '0;
              wd           <= '0;
              ex_addr      <= WB_DM_BASE;
              ex_mem_rd_en <= 1'b1;
            end
          end
        S_WB_READ:
          if (wd == 5'd16) begin
            state   <= S_WB_REQ;
            mc_op   <= OP_WRITE;
            mc_addr <= wr_base + {10'd0, ln, 6'd0};
            wd      <= '0;
          end else if (wd == 5'd15) begin
            wd           <= 5'd16;
            ex_mem_rd_en <= 1'b0;
          end else begin
            wd      <= wd + 5'd1;
            ex_addr <= ex_addr + 16'd4;
          end
        S_WB_REQ:
          if (mc_ready) begin
            state <= S_WB_WAIT;
            mc_op <= OP_IDLE;
          end
        S_WB_WAIT:
          if (mc_tx_done) begin
            if (ln == WB_LAST) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state        <= S_WB_READ;
              ln           <= ln + 16'd1;
              wd           <= '0;
              ex_addr      <= WB_DM_BASE + {ln[9:0] + 10'd1, 6'd0};
              ex_mem_rd_en <= 1'b1;
            end
          end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
endmodule
